// File: rtl/tiny86_trace_pkg.sv
// Constants shared by the trace loader and the register-file decoder:
// register width, step size and the trace-order slot numbers.
package tiny86_trace_pkg;

    localparam int REG_W      = 32;
    localparam int NUM_REGS   = 10;
    localparam int RAW_REGS_W = REG_W * NUM_REGS;

    localparam int SLOT_EAX    = 0;
    localparam int SLOT_EBX    = 1;
    localparam int SLOT_ECX    = 2;
    localparam int SLOT_EDX    = 3;
    localparam int SLOT_ESI    = 4;
    localparam int SLOT_EDI    = 5;
    localparam int SLOT_ESP    = 6;
    localparam int SLOT_EBP    = 7;
    localparam int SLOT_EIP    = 8;
    localparam int SLOT_EFLAGS = 9;

    // Top bit of a slot inside raw_regs; slot 0 (eax) sits in the MSBs.
    function automatic int slot_msb(input int slot);
        return RAW_REGS_W - 1 - REG_W * slot;
    endfunction

endpackage

// File: rtl/trace_regfile_loader.sv
// Assembles the per-step register trace into one raw_regs block and hands it
// to the decoder, resynchronising on the start-of-step marker.
module trace_regfile_loader #(
    parameter int WORD_W   = tiny86_trace_pkg::REG_W,
    parameter int NUM_REGS = tiny86_trace_pkg::NUM_REGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_word,
    input  logic                       in_first,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W*NUM_REGS-1:0] raw_regs,
    output logic [31:0]                step_count,
    output logic                       err_resync
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(tiny86_trace_pkg::SLOT_EAX);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [WORD_W-1:0]  slots [NUM_REGS];

    logic               accept;
    logic               handoff;
    logic               slot_we;
    logic [IDX_W-1:0]   slot_sel;
    logic               step_done;
    logic               err_next;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        in_ready   = 1'b1;
        handoff    = 1'b0;
        slot_we    = 1'b0;
        slot_sel   = idx;
        err_next   = 1'b0;

        // FULL passes one word through only while the decoder is taking the
        // held block, since there is no second buffer.
        if (state == FULL) begin
            in_ready = out_ready;
            handoff  = out_ready;
        end

        accept = in_valid && in_ready;

        if (accept) begin
            if (in_first) begin
                slot_we  = 1'b1;
                slot_sel = IDX_FIRST;
                idx_next = IDX_FIRST + IDX_W'(1);
                err_next = (idx != IDX_FIRST);
            end else if (idx == IDX_FIRST) begin
                err_next = 1'b1;
            end else begin
                slot_we  = 1'b1;
                idx_next = idx + IDX_W'(1);
            end
        end

        step_done = slot_we && (slot_sel == IDX_LAST);
        if (step_done) begin
            idx_next = IDX_FIRST;
        end

        if (handoff) begin
            state_next = FILL;
        end
        if (step_done) begin
            state_next = FULL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            idx        <= IDX_FIRST;
            step_count <= '0;
            err_resync <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            err_resync <= err_next;
            if (handoff) begin
                step_count <= step_count + 32'd1;
            end
        end
    end

    // NOTE: the slot storage is reset as well, because raw_regs must read
    // zero during reset; it is only 10 words, so the reset fan-out is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                slots[k] <= '0;
            end
        end else if (slot_we) begin
            slots[slot_sel] <= in_word;
        end
    end

    assign out_valid = (state == FULL);

    always_comb begin
        raw_regs = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            raw_regs[WORD_W*(NUM_REGS-k)-1 -: WORD_W] = slots[k];
        end
    end

endmodule

// File: doc/trace_regfile_loader.md
Name: trace_regfile_loader

Overview:
- Upstream neighbour of the register-file decoder.
- Accepts the per-step register trace as a stream of 32-bit words over a valid/ready handshake and assembles the 320-bit raw_regs block.
- Presents each completed block to the decoder with valid/ready and keeps a running step count.
- Resynchronises on a start-of-step marker so one corrupted step cannot misalign later steps.

Parameters:
- WORD_W, 32, width of one trace word / one register.
- NUM_REGS, 10, registers per step, in trace order eax, ebx, ecx, edx, esi, edi, esp, ebp, eip, eflags.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_word/in_first valid this cycle.
- in_ready  output  1  loader accepts the word this cycle.
- in_word  input  WORD_W  trace word.
- in_first  input  1  marks word 0 (eax) of a step.
- out_valid  output  1  raw_regs holds a complete step.
- out_ready  input  1  decoder consumes the step this cycle.
- raw_regs  output  WORD_W*NUM_REGS  assembled step, word k at bits [319-32k -: 32]; eax in the MSBs, eflags in the LSBs.
- step_count  output  32  number of steps handed off.
- err_resync  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset is asynchronous and active-high: while rst is asserted, state=FILL, idx=0, out_valid=0, raw_regs=0, step_count=0, err_resync=0.
- Accept means in_valid && in_ready. All register updates happen on the rising clk edge.
- FSM states FILL and FULL.
- FILL:
  - in_ready=1.
  - On accept with in_first=1: the word goes to slot 0 and idx becomes 1. If idx was not 0, the partial step is discarded and err_resync pulses.
  - On accept with in_first=0 and idx=0: the word is dropped, idx stays 0, err_resync pulses.
  - On accept with in_first=0 and idx in 1..NUM_REGS-1: the word goes to slot idx and idx increments.
  - When the word for slot NUM_REGS-1 is accepted: go to FULL, out_valid=1 from the next cycle, idx=0.
- FULL:
  - out_valid=1 and raw_regs is stable.
  - in_ready = out_ready (one-word pass-through; no extra buffer).
  - On out_valid && out_ready: step_count increments (wraps 2^32-1 -> 0) and the state returns to FILL.
  - If a word is accepted in the same cycle, it is processed by the FILL rules above (typically word 0 of the next step).
  - Slot 0 overwrite occurs only on the handoff edge, so the decoder sees the old value.
- Latency: out_valid asserts the cycle after the 10th word is accepted. Minimum 10 cycles per step at full throughput with out_ready held at 1.
- raw_regs contents are unspecified when out_valid=0 (stale slots allowed). Bench checks raw_regs only while out_valid=1.
- err_resync is registered: high exactly one cycle after the offending accept. Back-to-back errors produce consecutive pulses.
- An rst assertion mid-step discards the partial step and clears all outputs immediately; no handoff occurs.
- in_word/in_first are ignored when in_valid=0. out_ready is ignored when out_valid=0.

Decomposition:
- Shared package tiny86_trace_pkg holds REG_W=32, NUM_REGS=10, RAW_REGS_W=320, and the slot index constants (SLOT_EAX=0 .. SLOT_EFLAGS=9) in trace order.
- The package and this block share those constants with the register-file decoder.
- FSM state enum {FILL, FULL} is local to the module.
- No sub-module: one flat module with a slot-write decoder, an idx counter and the step counter.

Test Plan:
- Stream words 0x1000_0000..0x1000_0009 (first=1 on word 0) with out_ready=1: out_valid rises one cycle after the last accept; eax=0x1000_0000, eflags=0x1000_0009; step_count 0 -> 1.
- Three back-to-back steps with out_ready=1 and in_valid=1 continuously: in_ready never drops, steps are 10 cycles apart, step_count=3, each block is correct.
- Hold out_ready=0 for 5 cycles after a full step: in_ready=0 and raw_regs stable. Release with word 0 of the next step pending: handoff and accept occur in the same cycle, and the next block's eax is correct.
- Send 4 words, then a word with in_first=1 (0xDEAD_0000) plus 9 more: one err_resync pulse, only one step emitted, its eax=0xDEAD_0000.
- Send in_first=0 words when idx=0: each is dropped with one err_resync pulse, step_count unchanged, the following framed step is emitted intact.
- Assert rst after 6 words, and separately while out_valid=1: outputs go to 0 asynchronously; a subsequent full step is emitted correctly with step_count=1.
